ksa_arbiter: RTL and testbench

KSA_ARBITER -- requirements
Module: ksa_arbiter

---
 rtl/ksa_arbiter.sv | 134 +++++++++++++
 tb/tb_ksa_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ksa_arbiter.sv
// ksa_arbiter: two requesters share one 64-bit Kogge-Stone adder behind a
// one-entry registered output stage with valid/ready handshakes.
// Ports: clk, rst (async, active-high);
//        req0/req1: valid, ready, a[63:0], b[63:0];
//        rsp: valid, ready, sum[63:0], cout, id;
//        cnt0/cnt1[15:0]: per-requester accepted-operation counters.
// Option: define KSA_ARB_ROUND_ROBIN_EN to alternate grants on ties.
//         Without it, requester 0 always wins a tie.

module ksa64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum,
    output logic        cout
);
    // g[l]/p[l] are group generate/propagate after prefix level l.
    // Propagate is not needed past level 5, so it stops there.
    logic [63:0] g [0:6];
    logic [63:0] p [0:5];

    assign g[0] = a & b;
    assign p[0] = a ^ b;

    for (genvar l = 0; l < 6; l++) begin : g_lvl
        localparam int D = 1 << l;
        for (genvar i = 0; i < 64; i++) begin : g_bit
            if (i >= D) begin : g_op
                assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-D]);
                if (l < 5) begin : g_p
                    assign p[l+1][i] = p[l][i] & p[l][i-D];
                end
            end else begin : g_pass
                assign g[l+1][i] = g[l][i];
                if (l < 5) begin : g_p
                    assign p[l+1][i] = p[l][i];
                end
            end
        end
    end

    // Carry into bit i is the group generate of bits [i-1:0].
    assign sum  = p[0] ^ {g[6][62:0], 1'b0};
    assign cout = g[6][63];
endmodule

module ksa_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_sum,
    output logic        rsp_cout,
    output logic        rsp_id,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t      state;
    logic        last_grant;
    logic        can_accept;
    logic        prefer0;
    logic        grant0;
    logic        grant1;
    logic        xfer;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [63:0] add_sum;
    logic        add_cout;

    assign rsp_valid  = (state == FULL);
    assign can_accept = !rsp_valid | rsp_ready;

`ifdef KSA_ARB_ROUND_ROBIN_EN
    // last_grant == 1 means requester 1 went last, so 0 takes the tie.
    assign prefer0 = last_grant;
`else
    // Pointer is still tracked but can never override fixed priority.
    assign prefer0 = last_grant | 1'b1;
`endif

    // Grants depend only on the valids, never on the other ready.
    assign grant0 = req0_valid & (!req1_valid | prefer0);
    assign grant1 = req1_valid & !grant0;

    assign req0_ready = grant0 & can_accept & !rst;
    assign req1_ready = grant1 & can_accept & !rst;
    assign xfer       = req0_ready | req1_ready;

    assign op_a = grant1 ? req1_a : req0_a;
    assign op_b = grant1 ? req1_b : req0_b;

    ksa64 u_ksa64 (
        .a    (op_a),
        .b    (op_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            rsp_id     <= 1'b0;
            cnt0       <= '0;
            cnt1       <= '0;
            last_grant <= 1'b1;
        end else begin
            if (xfer) begin
                state      <= FULL;
                rsp_sum    <= add_sum;
                rsp_cout   <= add_cout;
                rsp_id     <= grant1;
                last_grant <= grant1;
                if (grant1) begin
                    cnt1 <= cnt1 + 16'd1;
                end else begin
                    cnt0 <= cnt0 + 16'd1;
                end
            end else if (state == FULL && rsp_ready) begin
                state <= EMPTY;
            end
        end
    end
endmodule

// File: tb/tb_ksa_arbiter.sv
// tb_ksa_arbiter: directed-vector bench for ksa_arbiter.
// Expected values are hand-computed; build with or without round-robin.

module tb_ksa_arbiter;
    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_id;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int n_run;
    int n_fail;

    ksa_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_id     (rsp_id),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tie sequence expectations for the two builds.
    logic [3:0] tie_ids;
    logic [15:0] exp_c0;
    logic [15:0] exp_c1;
    logic        hold_id;
    logic [63:0] hold_sum;

    initial begin
        n_run  = 0;
        n_fail = 0;
`ifdef KSA_ARB_ROUND_ROBIN_EN
        tie_ids = 4'b1010;
`else
        tie_ids = 4'b0000;
`endif
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_a     = 64'd998;
        req0_b     = 64'd128;
        req1_a     = '0;
        req1_b     = '0;
        rsp_ready  = 1'b1;
        #1;
        check("rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_sum", rsp_sum, 64'd0);
        check("rst_cnt0", {48'd0, cnt0}, 64'd0);
        check("rst_cnt1", {48'd0, cnt1}, 64'd0);
        tick();
        check("rst_ready0", {63'd0, req0_ready}, 64'd0);
        check("rst_valid2", {63'd0, rsp_valid}, 64'd0);

        // Release; req0 is already waiting and must go on the first edge.
        rst = 1'b0;
        #1;
        check("first_ready0", {63'd0, req0_ready}, 64'd1);
        tick();
        check("r0_valid", {63'd0, rsp_valid}, 64'd1);
        check("r0_sum", rsp_sum, 64'd1126);
        check("r0_cout", {63'd0, rsp_cout}, 64'd0);
        check("r0_id", {63'd0, rsp_id}, 64'd0);
        check("r0_cnt0", {48'd0, cnt0}, 64'd1);

        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_a     = 64'd9998;
        req1_b     = 64'd9028;
        tick();
        check("r1_sum", rsp_sum, 64'd19026);
        check("r1_cout", {63'd0, rsp_cout}, 64'd0);
        check("r1_id", {63'd0, rsp_id}, 64'd1);
        check("r1_cnt1", {48'd0, cnt1}, 64'd1);

        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_a     = 64'hFAAAAAAAFAAAAAAA;
        req0_b     = 64'hFAAAAAAADBBBBBBB;
        tick();
        check("big_sum", rsp_sum, 64'hF5555555D6666665);
        check("big_cout", {63'd0, rsp_cout}, 64'd1);
        check("big_cnt0", {48'd0, cnt0}, 64'd2);

        // Reset mid-operation while FULL: must clear without a clock edge.
        req0_valid = 1'b0;
        rsp_ready  = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", {63'd0, rsp_valid}, 64'd0);
        check("arst_cnt0", {48'd0, cnt0}, 64'd0);
        check("arst_cnt1", {48'd0, cnt1}, 64'd0);
        check("arst_sum", rsp_sum, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_nores", {63'd0, rsp_valid}, 64'd0);

        // rsp_ready while EMPTY is ignored.
        rsp_ready = 1'b1;
        tick();
        check("empty_rdy", {63'd0, rsp_valid}, 64'd0);

        // Tie arbitration, one result per cycle.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = 64'd1;
        req0_b = 64'd2;
        req1_a = 64'd10;
        req1_b = 64'd20;
        exp_c0 = 16'd0;
        exp_c1 = 16'd0;
        for (int i = 0; i < 4; i++) begin
            check("tie_ready1", {63'd0, req1_ready}, {63'd0, tie_ids[i]});
            tick();
            if (tie_ids[i]) exp_c1 = exp_c1 + 16'd1;
            else exp_c0 = exp_c0 + 16'd1;
            check("tie_id", {63'd0, rsp_id}, {63'd0, tie_ids[i]});
            check("tie_sum", rsp_sum, tie_ids[i] ? 64'd30 : 64'd3);
            check("tie_valid", {63'd0, rsp_valid}, 64'd1);
        end
        check("tie_cnt0", {48'd0, cnt0}, {48'd0, exp_c0});
        check("tie_cnt1", {48'd0, cnt1}, {48'd0, exp_c1});

        // Backpressure: output must hold, nobody accepted.
        hold_id  = tie_ids[3];
        hold_sum = tie_ids[3] ? 64'd30 : 64'd3;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ready0", {63'd0, req0_ready}, 64'd0);
            check("bp_ready1", {63'd0, req1_ready}, 64'd0);
            tick();
            check("bp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_sum", rsp_sum, hold_sum);
            check("bp_id", {63'd0, rsp_id}, {63'd0, hold_id});
        end
        check("bp_cnt0", {48'd0, cnt0}, {48'd0, exp_c0});

        // Drain and accept on the same edge; requester 0 wins in both builds.
        rsp_ready = 1'b1;
        #1;
        check("nb_ready0", {63'd0, req0_ready}, 64'd1);
        tick();
        check("nb_valid", {63'd0, rsp_valid}, 64'd1);
        check("nb_id", {63'd0, rsp_id}, 64'd0);
        check("nb_sum", rsp_sum, 64'd3);
        check("nb_cnt0", {48'd0, cnt0}, {48'd0, exp_c0 + 16'd1});

        // Drain with nothing pending.
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("drain", {63'd0, rsp_valid}, 64'd0);

        // Counter wrap: 65535 accepts reach FFFF, one more wraps to 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        check("wrap_ffff", {48'd0, cnt0}, 64'h0000_0000_0000_FFFF);
        tick();
        check("wrap_zero", {48'd0, cnt0}, 64'd0);
        check("wrap_cnt1", {48'd0, cnt1}, 64'd0);
        req0_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
